bayer_mosaic: RTL and testbench
===============================

# bayer_mosaic

Re-mosaic stage that converts a full-RGB pixel stream back into a single-channel Bayer stream. Each output word carries the 4-bit one-hot CFA tag in its low bits, in the same format the `demosaic` stage consumes. The block sits after the RGB pipeline, for sensor-model loopback and for raw-domain re-injection. It counts pixel positions per frame, selects one channel per site according to a runtime CFA pattern, and flags the last pixel of every frame.

## Interface
Parameters:
- `PIX_W`, 12: width of each colour channel and of the output pixel field.
- `TAG_W`, 4: width of the one-hot CFA tag (fixed).

Ports:
- `isp_clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redVec`  in  PIX_W  red input pixel.
- `greVec`  in  PIX_W  green input pixel.
- `bluVec`  in  PIX_W  blue input pixel.
- `dataEn`  in  1  input pixel valid.
- `h_active`  in  12  pixels per line.
- `v_active`  in  12  lines per frame.
- `bayer_pat`  in  2  CFA pattern: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
- `Dout`  out  PIX_W+TAG_W  {pixel, tag}.
- `doutEn`  out  1  output valid.
- `frame_done`  out  1  one-cycle pulse marking the last pixel of the frame.

## Operation
- Tag encoding in `Dout[3:0]`: bit0 = Gb, bit1 = B, bit2 = R, bit3 = Gr. Exactly one bit is set when `doutEn` = 1.
- Site mapping for pattern 0 (RGGB):
  - (even row, even col) = R
  - (even, odd) = Gr
  - (odd, even) = Gb
  - (odd, odd) = B
- Patterns 1–3 are the same 2×2 cell shifted by one column (1), one row (2), or both (3).
- Pixel selection: R sites take `redVec`, B sites take `bluVec`, Gr and Gb sites take `greVec`. The result goes to `Dout[15:4]`.
- Position counters `col` and `row` (12 bit each) advance only on `dataEn`.
  - `col` wraps to 0 after `h_active-1`; `row` increments on that wrap.
  - After (`h_active-1`, `v_active-1`) both counters return to 0.
- Frame start is the first `dataEn` with `col` = `row` = 0. At that cycle `h_active`, `v_active`, and `bayer_pat` are latched and held for the whole frame; mid-frame changes are ignored.
- Sizes below 2 are clamped to 2 when latched.
- `dataEn` gaps of any length are allowed. Counters and the output hold through a gap, and `doutEn` drops.

## Timing
- Latency is 1 cycle: `dataEn` at edge N gives `doutEn` and `Dout` at edge N+1.
- `frame_done` is high in the same cycle as `doutEn` for the last pixel of the frame, and only then.
- Reset values: `Dout` = 0, `doutEn` = 0, `frame_done` = 0, counters = 0. Latched size defaults to 2×2; latched pattern defaults to 0.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). The next `dataEn` after release is frame start at (0,0).
- A new frame may start in the cycle directly after the last pixel, with no idle cycle needed.

## Configuration
- `MOSAIC_TPG_EN` defined:
  - Adds input `tpg_en` (1 bit), latched at frame start.
  - When latched high, the RGB inputs are replaced by 8 vertical colour bars of width `h_active>>3`, in order white, yellow, cyan, green, magenta, red, blue, black, with full scale = 12'hFFF.
  - When `h_active>>3` = 0, the bar index saturates at 7 (black). Every other `col` and `row` behaviour is unchanged.
  - Timing and tagging are unchanged.
- `MOSAIC_TPG_EN` undefined: no `tpg_en` port, and RGB inputs are always used.

## Structure
- Shared package `isp_bayer_pkg` holds:
  - tag bit-position constants (GB = 0, B = 1, R = 2, GR = 3);
  - the `bayer_pat` enum;
  - the `PIX_W` and `TAG_W` defaults;
  - the TPG bar colour constants.
- One sub-module, `bayer_pos_cnt`, owns:
  - size latching and clamping;
  - the `col`/`row` counters;
  - frame start and last-pixel flags.
- The top level does pattern decode, channel select, the optional TPG, and the output register.

## Test plan
- 4×2 frame, pattern 0, R=0x100, G=0x200, B=0x300 continuous → row 0 `Dout` = 0x1004, 0x2008, 0x1004, 0x2008; row 1 = 0x2001, 0x3002, 0x2001, 0x3002; `frame_done` only with the 8th output.
- Same frame, pattern 3 → first output 0x3002, fifth output (row 1, col 0) 0x2008.
- Random `dataEn` gaps over a 6×4 frame → exactly 24 outputs, tags identical to the gap-free run, `frame_done` once.
- `bayer_pat` and `h_active` changed mid-frame → no effect until the next frame start.
- `rst` pulsed at pixel 5 of a 4×2 frame → outputs zero at once; the next input is tagged as (0,0) R for pattern 0.
- `MOSAIC_TPG_EN` defined, `tpg_en`=1, 16×2 frame, pattern 0 → cols 0–1 output 0xFFF4, 0xFFF8; cols 14–15 output 0x0004, 0x0008.

Source files
------------

// File: rtl/isp_bayer_pkg.sv
// Shared definitions for the Bayer mosaic/demosaic stages: CFA tag bit positions,
// pattern encoding, default widths and test-pattern bar colours.
package isp_bayer_pkg;

  localparam int PIX_W_DEF = 12;
  localparam int TAG_W_DEF = 4;

  localparam int TAG_GB = 0;
  localparam int TAG_B  = 1;
  localparam int TAG_R  = 2;
  localparam int TAG_GR = 3;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } bayer_pat_e;

  // {R,G,B} full-scale enables for bars 0..7: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] tpg_bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [11:0] clamp_size(input logic [11:0] s);
    return (s < 12'd2) ? 12'd2 : s;
  endfunction

endpackage

// File: rtl/bayer_pos_cnt.sv
// Pixel position tracking: latches frame geometry and pattern at frame start,
// runs the col/row counters on valid pixels and flags first/last pixel of a frame.
module bayer_pos_cnt
  import isp_bayer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [11:0] h_active_i,
  input  logic [11:0] v_active_i,
  input  bayer_pat_e  pat_i,
  output logic [11:0] col_o,
  output logic        row_odd_o,
  output logic [11:0] h_eff_o,
  output bayer_pat_e  pat_eff_o,
  output logic        start_o,
  output logic        last_o
);

  logic [11:0] col_q, col_d, row_q, row_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  bayer_pat_e  pat_q, pat_d;
  logic [11:0] v_eff;
  logic        col_end, row_end;

  // The frame-start pixel itself must already see the newly latched settings.
  always_comb begin
    start_o   = en_i && (col_q == 12'd0) && (row_q == 12'd0);
    h_eff_o   = start_o ? clamp_size(h_active_i) : h_q;
    v_eff     = start_o ? clamp_size(v_active_i) : v_q;
    pat_eff_o = start_o ? pat_i : pat_q;
    col_end   = (col_q == h_eff_o - 12'd1);
    row_end   = (row_q == v_eff - 12'd1);
    last_o    = en_i && col_end && row_end;

    col_d = col_q;
    row_d = row_q;
    h_d   = h_q;
    v_d   = v_q;
    pat_d = pat_q;
    if (start_o) begin
      h_d   = h_eff_o;
      v_d   = v_eff;
      pat_d = pat_eff_o;
    end
    if (en_i) begin
      if (col_end) begin
        col_d = 12'd0;
        row_d = row_end ? 12'd0 : row_q + 12'd1;
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= 12'd0;
      row_q <= 12'd0;
      h_q   <= 12'd2;
      v_q   <= 12'd2;
      pat_q <= PAT_RGGB;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      h_q   <= h_d;
      v_q   <= v_d;
      pat_q <= pat_d;
    end
  end

  assign col_o     = col_q;
  assign row_odd_o = row_q[0];

endmodule

// File: rtl/bayer_mosaic.sv
// RGB to single-channel Bayer re-mosaic with one-hot CFA tag in Dout[3:0].
// Optional colour-bar test pattern source enabled by defining MOSAIC_TPG_EN.
module bayer_mosaic
  import isp_bayer_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                   isp_clk,
  input  logic                   rst,
`ifdef MOSAIC_TPG_EN
  input  logic                   tpg_en,
`endif
  input  logic [PIX_W-1:0]       redVec,
  input  logic [PIX_W-1:0]       greVec,
  input  logic [PIX_W-1:0]       bluVec,
  input  logic                   dataEn,
  input  logic [11:0]            h_active,
  input  logic [11:0]            v_active,
  input  logic [1:0]             bayer_pat,
  output logic [PIX_W+TAG_W-1:0] Dout,
  output logic                   doutEn,
  output logic                   frame_done
);

  logic [11:0]            col, h_eff;
  logic                   row_odd, start, last;
  bayer_pat_e             pat_eff;
  logic [PIX_W-1:0]       r_in, g_in, b_in, pix;
  logic [TAG_W-1:0]       tag;
  logic [1:0]             site;
  logic [PIX_W+TAG_W-1:0] dout_q, dout_d;
  logic                   douten_q, fdone_q;

  bayer_pos_cnt u_pos (
    .clk_i      (isp_clk),
    .rst_i      (rst),
    .en_i       (dataEn),
    .h_active_i (h_active),
    .v_active_i (v_active),
    .pat_i      (bayer_pat_e'(bayer_pat)),
    .col_o      (col),
    .row_odd_o  (row_odd),
    .h_eff_o    (h_eff),
    .pat_eff_o  (pat_eff),
    .start_o    (start),
    .last_o     (last)
  );

`ifdef MOSAIC_TPG_EN
  logic        tpg_q, tpg_eff;
  logic [11:0] bar_div, bar_quo;
  logic [2:0]  bar_idx, bar_rgb;

  always_comb begin
    tpg_eff = start ? tpg_en : tpg_q;
    bar_div = (h_eff[11:3] == 9'd0) ? 12'd1 : {3'd0, h_eff[11:3]};
    bar_quo = col / bar_div;
    // Bars narrower than one pixel collapse onto the last (black) bar.
    if (h_eff[11:3] == 9'd0 || bar_quo > 12'd7) bar_idx = 3'd7;
    else                                        bar_idx = bar_quo[2:0];
    bar_rgb = tpg_bar_rgb(bar_idx);
    r_in    = tpg_eff ? {PIX_W{bar_rgb[2]}} : redVec;
    g_in    = tpg_eff ? {PIX_W{bar_rgb[1]}} : greVec;
    b_in    = tpg_eff ? {PIX_W{bar_rgb[0]}} : bluVec;
  end

  always_ff @(posedge isp_clk or posedge rst) begin
    if (rst)        tpg_q <= 1'b0;
    else if (start) tpg_q <= tpg_en;
  end
`else
  logic unused_tpg;
  assign unused_tpg = ^{col[11:1], h_eff};
  assign r_in = redVec;
  assign g_in = greVec;
  assign b_in = bluVec;
`endif

  // Patterns 1..3 are the RGGB cell shifted by a column (bit0) and/or a row (bit1).
  always_comb begin
    site = {row_odd ^ pat_eff[1], col[0] ^ pat_eff[0]};
    tag  = '0;
    pix  = g_in;
    case (site)
      2'b00: begin tag[TAG_R]  = 1'b1; pix = r_in; end
      2'b01: begin tag[TAG_GR] = 1'b1; pix = g_in; end
      2'b10: begin tag[TAG_GB] = 1'b1; pix = g_in; end
      default: begin tag[TAG_B] = 1'b1; pix = b_in; end
    endcase
    dout_d = dataEn ? {pix, tag} : dout_q;
  end

  always_ff @(posedge isp_clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      douten_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      douten_q <= dataEn;
      fdone_q  <= last;
    end
  end

  assign Dout       = dout_q;
  assign doutEn     = douten_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed bench for bayer_mosaic: frame-level reference model plus literal expectations.
module tb_bayer_mosaic;

  logic        isp_clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] redVec = '0, greVec = '0, bluVec = '0;
  logic        dataEn = 1'b0;
  logic [11:0] h_active = 12'd4, v_active = 12'd2;
  logic [1:0]  bayer_pat = 2'd0;
`ifdef MOSAIC_TPG_EN
  logic        tpg_en = 1'b0;
`endif
  logic [15:0] Dout;
  logic        doutEn, frame_done;

  bayer_mosaic dut (
    .isp_clk    (isp_clk),
    .rst        (rst),
`ifdef MOSAIC_TPG_EN
    .tpg_en     (tpg_en),
`endif
    .redVec     (redVec),
    .greVec     (greVec),
    .bluVec     (bluVec),
    .dataEn     (dataEn),
    .h_active   (h_active),
    .v_active   (v_active),
    .bayer_pat  (bayer_pat),
    .Dout       (Dout),
    .doutEn     (doutEn),
    .frame_done (frame_done)
  );

  always #5 isp_clk = ~isp_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference model: pixel index within the frame plus the settings captured at its start.
  int m_k = 0, m_h = 2, m_v = 2, m_pat = 0;
  bit m_tpg = 1'b0;
  logic [15:0] exp_dout = '0;
  bit exp_en = 1'b0, exp_fd = 1'b0;
  bit chk_on = 1'b0;
  // Tag per 2x2 cell position (row%2*2 + col%2); R=4, Gr=8, Gb=1, B=2.
  int tag_tab [4][4] = '{'{4, 8, 1, 2}, '{8, 4, 2, 1}, '{1, 2, 4, 8}, '{2, 1, 8, 4}};
  bit [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic model_reset();
    m_k = 0; m_h = 2; m_v = 2; m_pat = 0; m_tpg = 1'b0;
    exp_dout = '0; exp_en = 1'b0; exp_fd = 1'b0;
  endtask

  task automatic drive(input bit en);
    int row, col, tag, w, bar;
    logic [11:0] r, g, b, p;
    logic [15:0] nd;
    bit nfd;
    dataEn = en;
    nd = exp_dout;
    nfd = 1'b0;
    if (en) begin
      if (m_k == 0) begin
        m_h = (h_active < 12'd2) ? 2 : int'(h_active);
        m_v = (v_active < 12'd2) ? 2 : int'(v_active);
        m_pat = int'(bayer_pat);
`ifdef MOSAIC_TPG_EN
        m_tpg = tpg_en;
`endif
      end
      row = m_k / m_h;
      col = m_k % m_h;
      tag = tag_tab[m_pat][(row % 2) * 2 + (col % 2)];
      r = redVec; g = greVec; b = bluVec;
      if (m_tpg) begin
        w = m_h / 8;
        bar = (w == 0) ? 7 : ((col / w > 7) ? 7 : col / w);
        r = bar_rgb[bar][2] ? 12'hFFF : 12'h000;
        g = bar_rgb[bar][1] ? 12'hFFF : 12'h000;
        b = bar_rgb[bar][0] ? 12'hFFF : 12'h000;
      end
      p = (tag == 4) ? r : (tag == 2) ? b : g;
      nd = {p, tag[3:0]};
      nfd = (m_k == m_h * m_v - 1);
      m_k = nfd ? 0 : m_k + 1;
    end
    @(posedge isp_clk);
    #1;
    exp_dout = nd;
    exp_en = en;
    exp_fd = nfd;
  endtask

  logic [15:0] log_q [$];
  int fd_cnt = 0, fd_idx = -1;

  always @(negedge isp_clk) begin
    if (chk_on) begin
      chk("dout", int'(Dout), int'(exp_dout));
      chk("dout_en", int'(doutEn), int'(exp_en));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (doutEn) log_q.push_back(Dout);
      if (frame_done) begin
        fd_cnt++;
        fd_idx = log_q.size();
      end
    end
  end

  task automatic clear_log();
    log_q.delete();
    fd_cnt = 0;
    fd_idx = -1;
  endtask

  task automatic lchk(input string name, input int idx, input int exp_v);
    if (idx < log_q.size()) chk(name, int'(log_q[idx]), exp_v);
    else chk(name, -1, exp_v);
  endtask

  task automatic set_pix(input bit rnd);
    if (rnd) begin
      redVec = 12'($urandom_range(0, 4095));
      greVec = 12'($urandom_range(0, 4095));
      bluVec = 12'($urandom_range(0, 4095));
    end else begin
      redVec = 12'h100; greVec = 12'h200; bluVec = 12'h300;
    end
  endtask

  task automatic run_frame(input int h, input int v, input int pat, input int gaps, input bit rnd);
    int n;
    h_active = 12'(h);
    v_active = 12'(v);
    bayer_pat = 2'(pat);
    n = (h < 2 ? 2 : h) * (v < 2 ? 2 : v);
    for (int k = 0; k < n; k++) begin
      set_pix(rnd);
      drive(1'b1);
      if (gaps > 0) repeat ($urandom_range(0, gaps)) drive(1'b0);
    end
  endtask

  int ref_tags [$];
  int exp_row [8] = '{'h1004, 'h2008, 'h1004, 'h2008, 'h2001, 'h3002, 'h2001, 'h3002};

  initial begin
    repeat (2) @(negedge isp_clk);
    chk("reset_dout", int'(Dout), 0);
    chk("reset_en", int'(doutEn), 0);
    chk("reset_fd", int'(frame_done), 0);
    chk_on = 1'b1;
    @(negedge isp_clk);
    rst = 1'b0;
    @(posedge isp_clk);
    #1;

    // 4x2 RGGB frame followed directly by a 4x2 BGGR frame
    clear_log();
    run_frame(4, 2, 0, 0, 1'b0);
    run_frame(4, 2, 3, 0, 1'b0);
    drive(1'b0);
    drive(1'b0);
    chk("b2b_count", log_q.size(), 16);
    chk("b2b_fd_count", fd_cnt, 2);
    for (int i = 0; i < 8; i++) lchk("rggb_pix", i, exp_row[i]);
    lchk("bggr_first", 8, 'h3002);
    lchk("bggr_fifth", 12, 'h2008);

    // 6x4 GRBG, gap-free reference then with random gaps
    clear_log();
    run_frame(6, 4, 1, 0, 1'b1);
    drive(1'b0);
    ref_tags.delete();
    foreach (log_q[i]) ref_tags.push_back(int'(log_q[i][3:0]));
    clear_log();
    run_frame(6, 4, 1, 3, 1'b1);
    drive(1'b0);
    drive(1'b0);
    chk("gap_count", log_q.size(), 24);
    chk("gap_fd_count", fd_cnt, 1);
    chk("gap_fd_last", fd_idx, 24);
    for (int i = 0; i < 24 && i < ref_tags.size(); i++) lchk("gap_tag", i, ref_tags[i] | (int'(log_q[i]) & 'hFFF0));

    // Mid-frame changes of pattern and width take effect only at the next frame
    clear_log();
    h_active = 12'd4; v_active = 12'd2; bayer_pat = 2'd0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        bayer_pat = 2'd2;
        h_active = 12'd6;
      end
      set_pix(1'b0);
      drive(1'b1);
    end
    run_frame(6, 2, 2, 0, 1'b0);
    drive(1'b0);
    drive(1'b0);
    chk("mid_count", log_q.size(), 20);
    chk("mid_fd_count", fd_cnt, 2);
    lchk("mid_col3", 3, 'h2008);
    lchk("mid_last", 7, 'h3002);
    lchk("mid_next_start", 8, 'h2001);

    // Sizes below 2 clamp to a 2x2 frame
    clear_log();
    run_frame(1, 0, 0, 0, 1'b0);
    drive(1'b0);
    drive(1'b0);
    chk("clamp_count", log_q.size(), 4);
    chk("clamp_fd_pos", fd_idx, 4);
    lchk("clamp_last", 3, 'h3002);

    // Asynchronous reset after pixel 5 of a 4x2 frame
    h_active = 12'd4; v_active = 12'd2; bayer_pat = 2'd0;
    for (int k = 0; k < 5; k++) begin
      set_pix(1'b0);
      drive(1'b1);
    end
    dataEn = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_dout", int'(Dout), 0);
    chk("async_rst_en", int'(doutEn), 0);
    @(negedge isp_clk);
    rst = 1'b0;
    @(posedge isp_clk);
    #1;
    clear_log();
    run_frame(4, 2, 0, 0, 1'b0);
    drive(1'b0);
    drive(1'b0);
    lchk("post_rst_first", 0, 'h1004);
    chk("post_rst_fd_pos", fd_idx, 8);

`ifdef MOSAIC_TPG_EN
    // Colour bars over a 16x2 RGGB frame
    clear_log();
    tpg_en = 1'b1;
    run_frame(16, 2, 0, 0, 1'b1);
    tpg_en = 1'b0;
    drive(1'b0);
    drive(1'b0);
    lchk("tpg_col0", 0, 'hFFF4);
    lchk("tpg_col1", 1, 'hFFF8);
    lchk("tpg_col14", 14, 'h0004);
    lchk("tpg_col15", 15, 'h0008);
`endif

    drive(1'b0);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
